fetch_buffer: RTL and testbench

- Instruction fetch front end that sits directly upstream of decode.
- Owns the program counter and issues in-order word requests to instruction memory over a grant/valid handshake.
- Buffers returned instructions, each with its next-PC, in a small FIFO, and presents them to decode with valid/ready.
- Accepts PC redirects from write-back: flushes buffered words and discards stale in-flight responses.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/fetch_fifo.sv | 80 ++++++++
 rtl/fetch_buffer.sv | 160 ++++++++++++++++
 tb/tb_fetch_buffer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared constants and helpers for the CPU front end.
//   INST_W / PC_W     : instruction and program-counter widths
//   PC_STEP           : byte increment between sequential instruction words
//   RESET_PC_DEFAULT  : default fetch address after reset
//   fetch_entry_t     : one buffered fetch result {instruction, next PC}
//   pc_incr/pc_align  : sequential PC step and word alignment of a target PC
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int unsigned INST_W  = 32;
   localparam int unsigned PC_W    = 32;
   localparam int unsigned ENTRY_W = INST_W + PC_W;

   localparam logic [PC_W-1:0] PC_STEP          = 32'd4;
   localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [PC_W-1:0]   npc;
   } fetch_entry_t;

   // Sequential successor; wraps naturally at 2^32.
   function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] pc);
      return pc + PC_STEP;
   endfunction

   // Instruction words are 4-byte aligned, so the low two bits are dropped.
   function automatic logic [PC_W-1:0] pc_align(input logic [PC_W-1:0] pc);
      return {pc[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO holding fetched {instruction, next PC} entries.
// The caller guarantees it never pushes when full nor pops when empty.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   flush             : empties the FIFO; wins over push/pop in the same cycle
//   push, push_entry  : write one entry at the tail
//   pop               : retire the head entry
//   head_entry        : current head (registered storage, valid when count!=0)
//   count             : number of valid entries (0..DEPTH)
// -----------------------------------------------------------------------------
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [ENTRY_W-1:0]       push_entry,
   input  logic                     pop,
   output logic [ENTRY_W-1:0]       head_entry,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [ENTRY_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [CNT_W-1:0]   count_r;

   // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap freely.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
      end else if (flush) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
      end else begin
         if (push) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; cleared on reset so the head reads as zero out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {ENTRY_W{1'b0}};
         end
      end else if (push && !flush) begin
         mem_r[wr_ptr_r] <= push_entry;
      end
   end

   assign head_entry = mem_r[rd_ptr_r];
   assign count      = count_r;

endmodule

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Instruction fetch front end feeding decode. Owns the PC, issues in-order
// word requests, buffers returned words with their next PC, and handles
// redirects by flushing the buffer and discarding stale in-flight responses.
// Ports:
//   clk, rst                     : clock, asynchronous active-low reset
//   imem_req, imem_addr          : fetch request and its word address (PC)
//   imem_gnt                     : memory accepts the request this cycle
//   imem_rvalid, imem_rdata      : in-order response
//   redirect, redirect_pc        : PC override from write-back
//   inst_valid, inst, inst_npc   : FIFO head presented to decode
//   inst_ready                   : decode consumes the head this cycle
// -----------------------------------------------------------------------------
module fetch_buffer
   import cpu_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [INST_W-1:0] imem_rdata,
   input  logic              redirect,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst,
   output logic [PC_W-1:0]   inst_npc,
   input  logic              inst_ready
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int SUM_W = CNT_W + 1;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [SUM_W-1:0] DEPTH_S  = SUM_W'(DEPTH);

   logic [PC_W-1:0]  pc_r;
   logic [PC_W-1:0]  resp_pc_r;
   logic [CNT_W-1:0] inflight_r;
   logic [CNT_W-1:0] drop_r;
   logic             req_r;

   logic [PC_W-1:0]  pc_nxt_s;
   logic [PC_W-1:0]  resp_pc_nxt_s;
   logic [CNT_W-1:0] inflight_nxt_s;
   logic [CNT_W-1:0] drop_nxt_s;
   logic [CNT_W-1:0] count_nxt_s;
   logic             req_nxt_s;

   logic             grant_s;
   logic             push_s;
   logic             pop_s;
   logic             drop_hit_s;
   logic             inst_valid_s;
   logic [CNT_W-1:0] fifo_count_s;
   fetch_entry_t     push_entry_s;
   fetch_entry_t     head_entry_s;

   assign grant_s      = req_r & imem_gnt;
   assign inst_valid_s = (fifo_count_s != CNT_ZERO);
   assign pop_s        = inst_valid_s & inst_ready;
   // A response in a redirect cycle belongs to the old stream even if drop is zero.
   assign push_s       = imem_rvalid & ~redirect & (drop_r == CNT_ZERO);
   assign drop_hit_s   = imem_rvalid & (drop_r != CNT_ZERO);

   assign push_entry_s.inst = imem_rdata;
   assign push_entry_s.npc  = pc_incr(resp_pc_r);

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect),
      .push       (push_s),
      .push_entry (push_entry_s),
      .pop        (pop_s),
      .head_entry (head_entry_s),
      .count      (fifo_count_s)
   );

   // Next-state for PC tracking, credit counters and the registered request.
   always_comb begin
      pc_nxt_s       = pc_r;
      resp_pc_nxt_s  = resp_pc_r;
      drop_nxt_s     = drop_r;
      inflight_nxt_s = inflight_r;
      count_nxt_s    = fifo_count_s;

      // Outstanding requests are tracked the same way with or without a redirect.
      case ({grant_s, imem_rvalid})
         2'b10:   inflight_nxt_s = inflight_r + CNT_ONE;
         2'b01:   inflight_nxt_s = inflight_r - CNT_ONE;
         default: inflight_nxt_s = inflight_r;
      endcase

      if (redirect) begin
         pc_nxt_s      = pc_align(redirect_pc);
         resp_pc_nxt_s = pc_align(redirect_pc);
         // Everything still outstanding after this cycle is from the old stream.
         drop_nxt_s    = inflight_nxt_s;
         count_nxt_s   = CNT_ZERO;
      end else begin
         if (grant_s) begin
            pc_nxt_s = pc_incr(pc_r);
         end else begin
            pc_nxt_s = pc_r;
         end
         if (push_s) begin
            resp_pc_nxt_s = pc_incr(resp_pc_r);
         end else begin
            resp_pc_nxt_s = resp_pc_r;
         end
         if (drop_hit_s) begin
            drop_nxt_s = drop_r - CNT_ONE;
         end else begin
            drop_nxt_s = drop_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_nxt_s = fifo_count_s + CNT_ONE;
            2'b01:   count_nxt_s = fifo_count_s - CNT_ONE;
            default: count_nxt_s = fifo_count_s;
         endcase
      end

      // Buffered plus in-flight words may never exceed the FIFO depth, which
      // is what makes a push into a full FIFO impossible.
      req_nxt_s = (({1'b0, count_nxt_s} + {1'b0, inflight_nxt_s}) < DEPTH_S);
   end

   // State registers; the request is registered so it has no path from inputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_r       <= RESET_PC;
         resp_pc_r  <= RESET_PC;
         inflight_r <= CNT_ZERO;
         drop_r     <= CNT_ZERO;
         req_r      <= 1'b0;
      end else begin
         pc_r       <= pc_nxt_s;
         resp_pc_r  <= resp_pc_nxt_s;
         inflight_r <= inflight_nxt_s;
         drop_r     <= drop_nxt_s;
         req_r      <= req_nxt_s;
      end
   end

   assign imem_req   = req_r;
   assign imem_addr  = pc_r;
   assign inst_valid = inst_valid_s;
   assign inst       = head_entry_s.inst;
   assign inst_npc   = head_entry_s.npc;

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b0;
   logic        imem_req, imem_gnt, imem_rvalid, redirect, inst_valid, inst_ready;
   logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_npc;

   logic        w_req, w_gnt, w_rvalid, w_redirect, w_valid, w_ready;
   logic [31:0] w_addr, w_rdata, w_redirect_pc, w_inst, w_npc;

   fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst(inst), .inst_npc(inst_npc), .inst_ready(inst_ready)
   );

   fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .rst(rst),
      .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
      .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
      .redirect(w_redirect), .redirect_pc(w_redirect_pc),
      .inst_valid(w_valid), .inst(w_inst), .inst_npc(w_npc), .inst_ready(w_ready)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Instruction memory contents: a fixed scramble of the address.
   function automatic logic [31:0] memw(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A17};
   endfunction

   // ---------------- reference model ----------------
   // Memory holds requests in order; each remembers the stream (epoch) it
   // was issued in. Decode must see exactly the words of the current stream,
   // in order, each tagged with its address + 4.
   typedef struct {
      logic [31:0] addr;
      logic [31:0] tag_pc;
      int          epoch;
      int          due;
   } pend_t;
   typedef struct {
      logic [31:0] inst;
      logic [31:0] npc;
   } word_t;

   pend_t       pend_q[$];
   word_t       mq[$];
   logic [31:0] exp_pc;
   int          epoch, cyc, last_due, grants_seen, lat_min, lat_max;

   task automatic idle_inputs();
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
      w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = 32'h0;
      w_redirect = 1'b0; w_redirect_pc = 32'h0; w_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      pend_q.delete(); mq.delete();
      exp_pc = 32'h0; epoch = 0; cyc = 0; last_due = 0; grants_seen = 0;
      repeat (2) @(negedge clk);
      chk("rst_req", imem_req, 32'd0);
      chk("rst_valid", inst_valid, 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_npc", inst_npc, 32'h0);
      chk("rst_w_addr", w_addr, 32'hFFFF_FFFC);
      chk("rst_w_req", w_req, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_req", imem_req, 32'd1);
      chk("post_rst_addr", imem_addr, 32'h0);
   endtask

   // One cycle against the model: check outputs, drive inputs, update model.
   task automatic model_cycle(input logic gnt, input logic ready, input logic redir,
                              input logic [31:0] rpc);
      logic        req_s, valid_s, rv;
      logic [31:0] addr_s, rd;
      pend_t       p;
      word_t       w;
      int          due;
      req_s = imem_req; addr_s = imem_addr; valid_s = inst_valid;
      chk("m_req", req_s, ((mq.size() + pend_q.size()) < DEPTH) ? 32'd1 : 32'd0);
      if (req_s) chk("m_addr", addr_s, exp_pc);
      chk("m_valid", valid_s, (mq.size() != 0) ? 32'd1 : 32'd0);
      if (valid_s && mq.size() != 0) begin
         chk("m_inst", inst, mq[0].inst);
         chk("m_npc", inst_npc, mq[0].npc);
      end
      rv = (pend_q.size() != 0) && (pend_q[0].due <= cyc);
      rd = rv ? memw(pend_q[0].addr) : 32'h0;
      imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rd;
      inst_ready = ready; redirect = redir; redirect_pc = rpc;
      @(posedge clk);
      if (valid_s && ready && mq.size() != 0) w = mq.pop_front();
      if (rv) begin
         p = pend_q.pop_front();
         if (!redir && p.epoch == epoch) begin
            w.inst = memw(p.tag_pc);
            w.npc  = p.tag_pc + 32'd4;
            mq.push_back(w);
         end
      end
      if (req_s && gnt) begin
         due = cyc + int'($urandom_range(lat_max, lat_min));
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         p.addr = addr_s; p.tag_pc = exp_pc; p.epoch = epoch; p.due = due;
         pend_q.push_back(p);
         grants_seen++;
      end
      if (redir) begin
         mq.delete();
         epoch++;
         exp_pc = {rpc[31:2], 2'b00};
      end else if (req_s && gnt) begin
         exp_pc = exp_pc + 32'd4;
      end
      cyc++;
      @(negedge clk);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        gnt, rvalid;
      logic [31:0] rdata;
      logic        ready, redir;
      logic [31:0] rpc;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_inst, e_npc;
   } vec_t;

   vec_t vt[14];

   initial begin
      int nvalid;
      idle_inputs();

      // Two requests in flight, redirect to 0x100; then a redirect to 0x103
      // coinciding with both a grant and a response.
      vt[0]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h0, 32'h0};
      vt[1]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'h004, 1'b0, 32'h0, 32'h0};
      vt[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h100, 1'b1, 32'h008, 1'b0, 32'h0, 32'h0};
      vt[3]  = '{1'b1, 1'b1, 32'hDEAD_0000, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0, 32'h0};
      vt[4]  = '{1'b0, 1'b1, 32'hDEAD_0004, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0, 32'h0};
      vt[5]  = '{1'b0, 1'b1, 32'h1111_0100, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0, 32'h0};
      vt[6]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h1111_0100, 32'h104};
      vt[7]  = '{1'b1, 1'b1, 32'h2222_0104, 1'b1, 1'b1, 32'h103, 1'b1, 32'h108, 1'b0, 32'h0, 32'h0};
      vt[8]  = '{1'b0, 1'b1, 32'h3333_0108, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0, 32'h0};
      vt[9]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0, 32'h0};
      vt[10] = '{1'b0, 1'b1, 32'h4444_0100, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0, 32'h0};
      vt[11] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h4444_0100, 32'h104};
      vt[12] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h4444_0100, 32'h104};
      vt[13] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0, 32'h0};

      // Reset behaviour and directed table.
      do_reset();
      for (int i = 0; i < 14; i++) begin
         chk($sformatf("vec%0d_req", i), imem_req, vt[i].e_req);
         chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].e_addr);
         chk($sformatf("vec%0d_valid", i), inst_valid, vt[i].e_valid);
         if (vt[i].e_valid) begin
            chk($sformatf("vec%0d_inst", i), inst, vt[i].e_inst);
            chk($sformatf("vec%0d_npc", i), inst_npc, vt[i].e_npc);
         end
         imem_gnt = vt[i].gnt; imem_rvalid = vt[i].rvalid; imem_rdata = vt[i].rdata;
         inst_ready = vt[i].ready; redirect = vt[i].redir; redirect_pc = vt[i].rpc;
         @(negedge clk);
      end

      // Streaming with latency 1: no bubbles once filled.
      do_reset();
      lat_min = 1; lat_max = 1;
      repeat (3) model_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      nvalid = 0;
      for (int i = 0; i < 10; i++) begin
         if (inst_valid) nvalid++;
         model_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      end
      chk("stream_no_bubble", nvalid, 32'd10);

      // Decode stalled: credit runs out after exactly DEPTH grants.
      do_reset();
      repeat (10) model_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      chk("stall_grants", grants_seen, 32'd4);
      chk("stall_req", imem_req, 32'd0);
      chk("stall_inst", inst, memw(32'h0));
      chk("stall_npc", inst_npc, 32'h4);
      model_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      chk("resume_req", imem_req, 32'd1);
      chk("resume_addr", imem_addr, 32'h10);
      repeat (10) model_cycle(1'b1, 1'b1, 1'b0, 32'h0);

      // Randomized traffic against the model.
      do_reset();
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 3000; i++) begin
         model_cycle($urandom_range(3, 0) != 0,
                     (i < 1500) ? ($urandom_range(3, 0) == 0) : ($urandom_range(1, 0) == 1),
                     $urandom_range(15, 0) == 0,
                     $urandom);
      end

      // PC wrap at the top of the address space, then asynchronous reset.
      do_reset();
      chk("wrap_req0", w_req, 32'd1);
      chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
      w_gnt = 1'b1;
      @(negedge clk);
      chk("wrap_req1", w_req, 32'd1);
      chk("wrap_addr1", w_addr, 32'h0);
      w_rvalid = 1'b1; w_rdata = memw(32'hFFFF_FFFC);
      @(negedge clk);
      chk("wrap_valid1", w_valid, 32'd1);
      chk("wrap_inst1", w_inst, memw(32'hFFFF_FFFC));
      chk("wrap_npc1", w_npc, 32'h0);
      chk("wrap_addr2", w_addr, 32'h4);
      w_gnt = 1'b0; w_rdata = memw(32'h0);
      @(negedge clk);
      chk("wrap_hold_inst", w_inst, memw(32'hFFFF_FFFC));
      chk("wrap_hold_npc", w_npc, 32'h0);
      w_rvalid = 1'b0; w_ready = 1'b1;
      @(negedge clk);
      chk("wrap_valid2", w_valid, 32'd1);
      chk("wrap_inst2", w_inst, memw(32'h0));
      chk("wrap_npc2", w_npc, 32'h4);
      w_ready = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("async_w_req", w_req, 32'd0);
      chk("async_w_valid", w_valid, 32'd0);
      chk("async_w_addr", w_addr, 32'hFFFF_FFFC);
      chk("async_w_inst", w_inst, 32'h0);
      chk("async_w_npc", w_npc, 32'h0);
      chk("async_req", imem_req, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
